pmod_dac_tx: RTL and testbench

PMOD_DAC_TX -- requirements
Module: pmod_dac_tx

---
 rtl/pmod_dac_tx_pkg.sv | 37 +++
 rtl/pmod_dac_tx_if.sv | 52 +++++
 rtl/pmod_dac_tx_sclk_phase_gen.sv | 52 +++++
 rtl/pmod_dac_tx.sv | 139 +++++++++++++
 tb/tb_pmod_dac_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pmod_dac_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pmod_dac_tx_pkg                                              |
// | Description : Shared constants, FSM state encoding and frame-building       |
// |               helper for the dual-channel PMOD DAC serial transmitter.      |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package pmod_dac_tx_pkg;

  // Serial frame width: 2 don't-care bits, 2 power-down bits, 12 data bits.
  localparam int c_frame_w = 16;
  // MSB index of a DAC sample (samples are [c_sample_msb:0]).
  localparam int c_sample_msb = 11;
  // Default SCLK half-period in clk cycles.
  localparam int c_clk_div_default = 4;
  // Phase counter width; holds CLK_DIV-1 for CLK_DIV up to 255.
  localparam int c_phase_w = 8;
  // Bit counter width; counts 0..c_frame_w-1.
  localparam int c_bit_cnt_w = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_QUIET = 2'd2
  } state_t;

  // Frame word sent on each DAC data line, MSB first.
  function automatic logic [c_frame_w-1:0] build_frame(
    input logic [1:0]            pd,
    input logic [c_sample_msb:0] sample
  );
    return {2'b00, pd, sample};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmod_dac_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pmod_dac_tx_if                                               |
// | Description : Sample handshake, status and DAC pin bundle.                  |
// | Ports       : sample_a/sample_b/sample_valid (producer -> tx)               |
// |               sample_ready/busy/frame_done   (tx -> producer)               |
// |               dac_sync_n/dac_sclk/dac_din_a/dac_din_b (tx -> DAC pins)      |
// |               modport master = producer side, slave = transmitter side     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface pmod_dac_tx_if;
  import pmod_dac_tx_pkg::*;

  logic [c_sample_msb:0] sample_a;
  logic [c_sample_msb:0] sample_b;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  busy;
  logic                  frame_done;
  logic                  dac_sync_n;
  logic                  dac_sclk;
  logic                  dac_din_a;
  logic                  dac_din_b;

  modport master (
    output sample_a,
    output sample_b,
    output sample_valid,
    input  sample_ready,
    input  busy,
    input  frame_done,
    input  dac_sync_n,
    input  dac_sclk,
    input  dac_din_a,
    input  dac_din_b
  );

  modport slave (
    input  sample_a,
    input  sample_b,
    input  sample_valid,
    output sample_ready,
    output busy,
    output frame_done,
    output dac_sync_n,
    output dac_sclk,
    output dac_din_a,
    output dac_din_b
  );

endinterface
`default_nettype wire

// File: rtl/pmod_dac_tx_sclk_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sclk_phase_gen                                               |
// | Description : SCLK phase counter. While enabled, counts 0..CLK_DIV-1 and    |
// |               wraps, alternating between the high and low half of a bit.    |
// |               Emits a fall tick on the last cycle of a high half and a rise |
// |               tick on the last cycle of a low half.                         |
// | Ports       : clk, reset     clock / synchronous active-high reset          |
// |               i_en           count enable; low holds the counter cleared    |
// |               o_fall_tick    high half ends this cycle                      |
// |               o_rise_tick    low half (whole bit period) ends this cycle    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sclk_phase_gen
  import pmod_dac_tx_pkg::*;
#(
  parameter int CLK_DIV = c_clk_div_default
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_en,
  output logic      o_fall_tick,
  output logic      o_rise_tick
);

  localparam logic [c_phase_w-1:0] c_last_phase = c_phase_w'(CLK_DIV - 1);

  logic [c_phase_w-1:0] r_phase;
  logic                 r_low_half;  // 0 = high half of the bit, 1 = low half
  logic                 w_wrap;

  assign w_wrap = i_en && (r_phase == c_last_phase);

  // Holding the counter cleared while disabled guarantees each frame and each
  // quiet gap starts at phase 0 of a high half.
  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_phase    <= '0;
      r_low_half <= 1'b0;
    end else if (w_wrap) begin
      r_phase    <= '0;
      r_low_half <= ~r_low_half;
    end else begin
      r_phase    <= r_phase + 1'b1;
    end
  end

  assign o_fall_tick = w_wrap && !r_low_half;
  assign o_rise_tick = w_wrap &&  r_low_half;

endmodule
`default_nettype wire

// File: rtl/pmod_dac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pmod_dac_tx                                                  |
// | Description : Dual-channel serial DAC transmitter. Accepts a pair of 12-bit |
// |               samples, shifts two 16-bit frames out in lockstep under one   |
// |               SYNC/SCLK, then holds a quiet gap before the next accept.    |
// | Parameters  : CLK_DIV  SCLK half-period in clk cycles (1..255)             |
// |               PD_MODE  power-down field placed in frame bits [13:12]       |
// | Ports       : clk, reset  clock / synchronous active-high reset            |
// |               bus        pmod_dac_tx_if.slave (handshake, status, DAC pins) |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pmod_dac_tx
  import pmod_dac_tx_pkg::*;
#(
  parameter int         CLK_DIV = c_clk_div_default,
  parameter logic [1:0] PD_MODE = 2'b00
) (
  input  wire logic     clk,
  input  wire logic     reset,
  pmod_dac_tx_if.slave  bus
);

  localparam logic [c_bit_cnt_w-1:0] c_last_bit = c_bit_cnt_w'(c_frame_w - 1);

  state_t                 r_state,      w_state_nxt;
  logic [c_frame_w-1:0]   r_shift_a,    w_shift_a_nxt;
  logic [c_frame_w-1:0]   r_shift_b,    w_shift_b_nxt;
  logic [c_bit_cnt_w-1:0] r_bit_cnt,    w_bit_cnt_nxt;
  logic                   r_sync_n,     w_sync_n_nxt;
  logic                   r_sclk,       w_sclk_nxt;
  logic                   r_frame_done, w_frame_done_nxt;

  logic w_phase_en;
  logic w_fall_tick;
  logic w_rise_tick;

  // Phase generator runs through the whole frame and the quiet gap.
  assign w_phase_en = (r_state != ST_IDLE);

  sclk_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_phase_gen (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_phase_en),
    .o_fall_tick (w_fall_tick),
    .o_rise_tick (w_rise_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shift_a    <= '0;
      r_shift_b    <= '0;
      r_bit_cnt    <= '0;
      r_sync_n     <= 1'b1;
      r_sclk       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift_a    <= w_shift_a_nxt;
      r_shift_b    <= w_shift_b_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_sync_n     <= w_sync_n_nxt;
      r_sclk       <= w_sclk_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_a_nxt    = r_shift_a;
    w_shift_b_nxt    = r_shift_b;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_sync_n_nxt     = r_sync_n;
    w_sclk_nxt       = r_sclk;
    w_frame_done_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Accept: capture both samples and present bit 15 with SCLK high.
        if (bus.sample_valid) begin
          w_state_nxt   = ST_SHIFT;
          w_shift_a_nxt = build_frame(PD_MODE, bus.sample_a);
          w_shift_b_nxt = build_frame(PD_MODE, bus.sample_b);
          w_bit_cnt_nxt = '0;
          w_sync_n_nxt  = 1'b0;
          w_sclk_nxt    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (w_fall_tick) begin
          w_sclk_nxt = 1'b0;
        end else if (w_rise_tick) begin
          // Data only advances together with the rising SCLK edge, so it is
          // stable across the whole low half where the DAC samples it.
          w_sclk_nxt = 1'b1;
          if (r_bit_cnt == c_last_bit) begin
            w_state_nxt      = ST_QUIET;
            w_sync_n_nxt     = 1'b1;
            w_shift_a_nxt    = '0;
            w_shift_b_nxt    = '0;
            w_bit_cnt_nxt    = '0;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            w_shift_a_nxt = {r_shift_a[c_frame_w-2:0], 1'b0};
            w_shift_b_nxt = {r_shift_b[c_frame_w-2:0], 1'b0};
          end
        end
      end

      ST_QUIET: begin
        // The phase generator restarts at phase 0 on entry, so one full bit
        // period (2*CLK_DIV cycles) elapses before the rise tick.
        if (w_rise_tick) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.sample_ready = (r_state == ST_IDLE);
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.frame_done   = r_frame_done;
  assign bus.dac_sync_n   = r_sync_n;
  assign bus.dac_sclk     = r_sclk;
  // Shift registers are cleared outside a frame, so the data lines idle low.
  assign bus.dac_din_a    = r_shift_a[c_frame_w-1];
  assign bus.dac_din_b    = r_shift_b[c_frame_w-1];

endmodule
`default_nettype wire

// File: tb/tb_pmod_dac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pmod_dac_tx                                               |
// | Description : Directed self-checking bench for pmod_dac_tx. Two instances:  |
// |               u_dut0 (CLK_DIV=4, PD_MODE=00) and u_dut1 (CLK_DIV=1,         |
// |               PD_MODE=11). Cycle n=1 is the first sample after the accept   |
// |               edge.                                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pmod_dac_tx;

  logic clk;
  logic rst0;
  logic rst1;

  int checks = 0;
  int errors = 0;

  // Per-observation statistics.
  int          frame_idx;
  logic [15:0] bits_a [4];
  logic [15:0] bits_b [4];
  int          falls  [4];
  int          low_len[4];
  int          gap_len;
  int          high_run;
  int          fd_cnt;
  int          fd_first;
  int          rdy_first;
  int          din_bad;
  int          quiet_bad;
  logic [7:0]  sclk_hist;

  pmod_dac_tx_if tif0 ();
  pmod_dac_tx_if tif1 ();

  pmod_dac_tx #(.CLK_DIV(4), .PD_MODE(2'b00)) u_dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (tif0)
  );

  pmod_dac_tx #(.CLK_DIV(1), .PD_MODE(2'b11)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (tif1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) tif1.sample_valid = v;
    else     tif0.sample_valid = v;
  endtask

  task automatic set_samples(input bit sel, input logic [11:0] a, input logic [11:0] b);
    if (sel) begin tif1.sample_a = a; tif1.sample_b = b; end
    else     begin tif0.sample_a = a; tif0.sample_b = b; end
  endtask

  // Samples one DUT at every negedge for ncyc cycles and gathers statistics.
  // alt: toggle sample values every cycle; valid_off_at / mid_change_at: cycle
  // numbers at which valid is dropped / new values are offered while busy.
  task automatic observe(input bit sel, input int ncyc, input bit alt,
                         input int valid_off_at, input int mid_change_at);
    logic s_sync, s_sclk, s_da, s_db, s_fd, s_rdy;
    logic p_sync, p_sclk, p_da, p_db;
    frame_idx = -1; gap_len = -1; high_run = 0; fd_cnt = 0;
    fd_first = -1; rdy_first = -1; din_bad = 0; quiet_bad = 0; sclk_hist = '0;
    for (int k = 0; k < 4; k++) begin
      bits_a[k] = '0; bits_b[k] = '0; falls[k] = 0; low_len[k] = 0;
    end
    p_sync = 1'b1; p_sclk = 1'b1; p_da = 1'b0; p_db = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (sel) begin
        s_sync = tif1.dac_sync_n; s_sclk = tif1.dac_sclk; s_da = tif1.dac_din_a;
        s_db = tif1.dac_din_b; s_fd = tif1.frame_done; s_rdy = tif1.sample_ready;
      end else begin
        s_sync = tif0.dac_sync_n; s_sclk = tif0.dac_sclk; s_da = tif0.dac_din_a;
        s_db = tif0.dac_din_b; s_fd = tif0.frame_done; s_rdy = tif0.sample_ready;
      end
      if (n <= 8) sclk_hist[n-1] = s_sclk;
      if (!s_sync && p_sync) begin
        frame_idx++;
        if (frame_idx > 0) gap_len = high_run;
      end
      if (s_sync) high_run++;
      else begin
        high_run = 0;
        if (frame_idx >= 0 && frame_idx < 4) low_len[frame_idx]++;
      end
      if (!s_sync && p_sclk && !s_sclk && frame_idx >= 0 && frame_idx < 4) begin
        bits_a[frame_idx] = {bits_a[frame_idx][14:0], s_da};
        bits_b[frame_idx] = {bits_b[frame_idx][14:0], s_db};
        falls[frame_idx]++;
      end
      if (!s_sync && !p_sync && ((s_da != p_da) || (s_db != p_db)) && !(!p_sclk && s_sclk))
        din_bad++;
      if (s_sync && (s_da || s_db || !s_sclk)) quiet_bad++;
      if (s_fd) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = n;
      end
      if (s_rdy && rdy_first < 0) rdy_first = n;
      p_sync = s_sync; p_sclk = s_sclk; p_da = s_da; p_db = s_db;
      if (alt) begin
        if (n[0]) set_samples(sel, 12'hEEE, 12'hDDD);
        else      set_samples(sel, 12'h111, 12'h222);
      end
      if (n == mid_change_at) begin
        set_samples(sel, 12'h555, 12'hAAA);
        set_valid(sel, 1'b1);
      end
      if (n == valid_off_at) set_valid(sel, 1'b0);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    set_samples(0, '0, '0); set_valid(0, 1'b0);
    set_samples(1, '0, '0); set_valid(1, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready",  tif0.sample_ready, 1);
    check("rst_busy",   tif0.busy,         0);
    check("rst_sync_n", tif0.dac_sync_n,   1);
    check("rst_sclk",   tif0.dac_sclk,     1);
    check("rst_din_a",  tif0.dac_din_a,    0);
    check("rst_din_b",  tif0.dac_din_b,    0);
    check("rst_fd",     tif0.frame_done,   0);
    check("rst1_ready", tif1.sample_ready, 1);
    rst0 = 1'b0; rst1 = 1'b0;

    // Single frame A=ABC, B=123; new values offered mid-frame must be ignored.
    set_samples(0, 12'hABC, 12'h123); set_valid(0, 1'b1);
    observe(0, 140, 1'b0, 130, 5);
    check("f1_frames",    frame_idx,  0);
    check("f1_bits_a",    bits_a[0],  16'h0ABC);
    check("f1_bits_b",    bits_b[0],  16'h0123);
    check("f1_falls",     falls[0],   16);
    check("f1_sync_low",  low_len[0], 128);
    check("f1_fd_at",     fd_first,   129);
    check("f1_fd_cnt",    fd_cnt,     1);
    check("f1_ready_at",  rdy_first,  137);
    check("f1_sclk_hist", sclk_hist,  8'h0F);
    check("f1_din_stable", din_bad,   0);
    check("f1_quiet_pins", quiet_bad, 0);

    // Back-to-back with valid held and values alternating every cycle.
    set_samples(0, 12'h111, 12'h222); set_valid(0, 1'b1);
    observe(0, 272, 1'b1, 270, 0);
    check("b2b_frames",   frame_idx,  1);
    check("b2b_a0",       bits_a[0],  16'h0111);
    check("b2b_b0",       bits_b[0],  16'h0222);
    check("b2b_a1",       bits_a[1],  16'h0EEE);
    check("b2b_b1",       bits_b[1],  16'h0DDD);
    check("b2b_gap",      gap_len,    9);
    check("b2b_low1",     low_len[1], 128);
    check("b2b_fd_cnt",   fd_cnt,     2);
    repeat (4) @(negedge clk);
    check("b2b_idle_ready", tif0.sample_ready, 1);

    // Reset wins over an accept in the same cycle.
    rst0 = 1'b1; set_samples(0, 12'hFFF, 12'hFFF); set_valid(0, 1'b1);
    @(negedge clk);
    check("prio_ready",  tif0.sample_ready, 1);
    check("prio_sync_n", tif0.dac_sync_n,   1);
    rst0 = 1'b0;

    // Reset 50 cycles into a frame.
    observe(0, 50, 1'b0, 1, 0);
    check("mid_busy",   tif0.busy, 1);
    check("mid_fd_cnt", fd_cnt,    0);
    rst0 = 1'b1;
    @(negedge clk);
    check("abort_sync_n", tif0.dac_sync_n,   1);
    check("abort_sclk",   tif0.dac_sclk,     1);
    check("abort_din_a",  tif0.dac_din_a,    0);
    check("abort_din_b",  tif0.dac_din_b,    0);
    check("abort_ready",  tif0.sample_ready, 1);
    check("abort_fd",     tif0.frame_done,   0);
    rst0 = 1'b0;
    observe(0, 20, 1'b0, 0, 0);
    check("abort_no_frame", frame_idx, -1);
    check("abort_no_fd",    fd_cnt,    0);

    // CLK_DIV=1, PD_MODE=11 instance.
    set_samples(1, 12'hFFF, 12'h5A5); set_valid(1, 1'b1);
    observe(1, 40, 1'b0, 1, 0);
    check("d1_bits_a",    bits_a[0],  16'h3FFF);
    check("d1_bits_b",    bits_b[0],  16'h35A5);
    check("d1_falls",     falls[0],   16);
    check("d1_sync_low",  low_len[0], 32);
    check("d1_fd_at",     fd_first,   33);
    check("d1_ready_at",  rdy_first,  35);
    check("d1_sclk_hist", sclk_hist,  8'h55);
    check("d1_din_stable", din_bad,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
